// File: rtl/n_bit_array_multiplier.sv
// Unsigned N x N array multiplier built from AND-gate partial products and
// rows of ripple-carry adder cells. PROD is purely combinational. PROD_R is a
// registered copy with an asynchronous active-low clear.

// One-bit half adder cell; it sits at the LSB of each adder row.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    assign s  = a ^ b;
    assign co = a & b;
endmodule

// One-bit full adder cell; it fills every adder row position above the LSB.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module n_bit_array_multiplier #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] PROD,
    output logic [2*N-1:0] PROD_R
);

    // pp[i][j] = A[j] & B[i]
    logic [N-1:0] pp    [N];
    // acc[i] = {row carry-out, row sum bits}. Bit 0 is final product bit i,
    // and bits N:1 are the shifted input to the next row.
    logic [N:0]   acc   [N];
    // Ripple carries inside rows 1..N-1.
    logic [N-1:0] carry [1:N-1];

    for (genvar i = 0; i < N; i++) begin : g_pp
        assign pp[i] = A & {N{B[i]}};
    end

    // Row 0 has nothing to add to, so it passes straight through.
    assign acc[0] = {1'b0, pp[0]};

    for (genvar i = 1; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_cell
            if (j == 0) begin : g_ha
                half_adder u_ha (
                    .a  (pp[i][0]),
                    .b  (acc[i-1][1]),
                    .s  (acc[i][0]),
                    .co (carry[i][0])
                );
            end else begin : g_fa
                full_adder u_fa (
                    .a  (pp[i][j]),
                    .b  (acc[i-1][j+1]),
                    .ci (carry[i][j-1]),
                    .s  (acc[i][j]),
                    .co (carry[i][j])
                );
            end
        end
        assign acc[i][N] = carry[i][N-1];
    end

    for (genvar i = 0; i < N; i++) begin : g_prod_lo
        assign PROD[i] = acc[i][0];
    end
    assign PROD[2*N-1:N] = acc[N-1][N:1];

    // Registered product; reset clears it immediately without waiting for clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            PROD_R <= '0;
        end else begin
            PROD_R <= PROD;
        end
    end

endmodule

// File: tb/tb_n_bit_array_multiplier.sv
// Directed bench for n_bit_array_multiplier: combinational product vectors,
// walking ones, random operands, and register/reset behaviour of PROD_R.
module tb_n_bit_array_multiplier;

    localparam int unsigned N         = 8;
    localparam int          NUM_TESTS = 10;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2*N-1:0] PROD;
    logic [2*N-1:0] PROD_R;

    int checks;
    int failures;

    n_bit_array_multiplier #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .PROD    (PROD),
        .PROD_R  (PROD_R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*N-1:0] obs,
                         input logic [2*N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2*N-1:0] exp_prod;
        logic [2*N-1:0] prev_prod;
        logic [2*N-1:0] wa;
        logic [2*N-1:0] wb;

        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        A        = '0;
        B        = '0;

        // PROD_R held at zero while reset is asserted, even with clk running.
        #2;
        check("reset_prod_r_initial", PROD_R, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_prod_r_clocked", PROD_R, 16'd0);

        // Directed combinational vectors.
        A = 8'd0;    B = 8'hA5; #1; check("zero_a", PROD, 16'd0);
        A = 8'h5A;   B = 8'd0;  #1; check("zero_b", PROD, 16'd0);
        A = 8'd1;    B = 8'd200; #1; check("ident_a1", PROD, 16'd200);
        A = 8'd173;  B = 8'd1;  #1; check("ident_b1", PROD, 16'd173);
        A = 8'd255;  B = 8'd255; #1; check("max_corner", PROD, 16'hFE01);
        A = 8'd255;  B = 8'd2;  #1; check("ff_times_2", PROD, 16'd510);
        A = 8'd128;  B = 8'd255; #1; check("msb_times_ff", PROD, 16'd32640);
        A = 8'd15;   B = 8'd17; #1; check("f_times_11", PROD, 16'd255);

        // Walking ones.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                A = 8'(1 << i);
                B = 8'(1 << j);
                #1;
                exp_prod = 16'(1 << (i + j));
                check($sformatf("walk_a%0d_b%0d", i, j), PROD, exp_prod);
            end
        end

        // Register behaviour: release reset between edges.
        @(negedge clk);
        reset_n = 1'b1;
        A = 8'd12;
        B = 8'd11;
        #1;
        check("reg_prod_immediate", PROD, 16'd132);
        check("reg_prod_r_before_edge", PROD_R, 16'd0);
        @(posedge clk);
        #1;
        check("reg_prod_r_after_edge", PROD_R, 16'd132);
        #2;
        reset_n = 1'b0;
        #1;
        check("reg_async_clear", PROD_R, 16'd0);
        check("reg_prod_unaffected", PROD, 16'd132);

        // Random operands: new values just after each posedge, checked at negedge.
        @(negedge clk);
        reset_n   = 1'b1;
        prev_prod = 16'd132;
        for (int t = 0; t < NUM_TESTS; t++) begin
            @(posedge clk);
            #1;
            A = 8'($urandom);
            B = 8'($urandom);
            wa = 16'(A);
            wb = 16'(B);
            exp_prod = wa * wb;
            @(negedge clk);
            check($sformatf("rand_prod_test%0d", t), PROD, exp_prod);
            check($sformatf("rand_prod_r_test%0d", t), PROD_R, prev_prod);
            prev_prod = exp_prod;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
